// File: rtl/hpm_pkg.sv
// Shared definitions for the hardware performance-monitor counter bank:
// register-select encoding and CTRL register bit positions.
package hpm_pkg;

  typedef enum logic [1:0] {
    REG_COUNT   = 2'd0,
    REG_COMPARE = 2'd1,
    REG_CTRL    = 2'd2,
    REG_RSVD    = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_SAT   = 2;
  localparam int CTRL_IRQEN = 3;
  localparam int CTRL_OVF   = 8;
  localparam int CTRL_MATCH = 9;

endpackage

// File: rtl/hpm_counter_channel.sv
// One performance-counter channel: COUNT, COMPARE and CTRL registers,
// up/down step with wrap or saturate, sticky overflow/match status and
// a level interrupt built only from register outputs.
module hpm_counter_channel
  import hpm_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             event_pulse,
  input  logic             count_we,
  input  logic             compare_we,
  input  logic             ctrl_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] compare,
  output logic [WIDTH-1:0] ctrl,
  output logic             irq
);

  logic             en_q;
  logic             dir_q;
  logic             sat_q;
  logic             irq_en_q;
  logic             ovf_q;
  logic             match_q;

  logic             step;
  logic [WIDTH-1:0] step_value;
  logic             ovf_set;
  logic             match_set;

  // Next count for an event-driven step; a COUNT write in the same cycle
  // suppresses the step entirely, so it cannot raise ovf or match.
  always_comb begin
    step       = en_q & event_pulse & ~count_we;
    step_value = count;
    ovf_set    = 1'b0;
    if (dir_q) begin
      if (count == {WIDTH{1'b1}}) begin
        ovf_set    = 1'b1;
        step_value = sat_q ? count : '0;
      end else begin
        step_value = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        ovf_set    = 1'b1;
        step_value = sat_q ? count : {WIDTH{1'b1}};
      end else begin
        step_value = count - WIDTH'(1);
      end
    end
    ovf_set   = ovf_set & step;
    match_set = step & (step_value == compare);
  end

  // Register state: software writes, event steps, and W1C status where a
  // fresh set in the same cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      compare  <= {WIDTH{1'b1}};
      en_q     <= 1'b0;
      dir_q    <= 1'b0;
      sat_q    <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
      end else if (step) begin
        count <= step_value;
      end
      if (compare_we) begin
        compare <= wdata;
      end
      if (ctrl_we) begin
        en_q     <= wdata[CTRL_EN];
        dir_q    <= wdata[CTRL_DIR];
        sat_q    <= wdata[CTRL_SAT];
        irq_en_q <= wdata[CTRL_IRQEN];
      end
      ovf_q   <= ovf_set | (ovf_q & ~(ctrl_we & wdata[CTRL_OVF]));
      match_q <= match_set | (match_q & ~(ctrl_we & wdata[CTRL_MATCH]));
    end
  end

  // CTRL read image; unimplemented bits read as zero.
  always_comb begin
    ctrl             = '0;
    ctrl[CTRL_EN]    = en_q;
    ctrl[CTRL_DIR]   = dir_q;
    ctrl[CTRL_SAT]   = sat_q;
    ctrl[CTRL_IRQEN] = irq_en_q;
    ctrl[CTRL_OVF]   = ovf_q;
    ctrl[CTRL_MATCH] = match_q;
  end

  assign irq = match_q & irq_en_q;

endmodule

// File: rtl/hpm_counter_bank.sv
// Bank of independent performance counters behind a small register port.
// Register port handshake: rd_en and wr_en have no ready; every strobe is
// accepted in the cycle it is high. A read returns rdata with a one-cycle
// rd_valid pulse on the following edge, carrying the register value from
// before that edge; rdata holds its last value while rd_valid is low.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter  int WIDTH    = 64,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] event_i,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [SEL_W-1:0]    ch_sel,
  input  logic [1:0]          reg_sel,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata,
  output logic                rd_valid,
  output logic [CHANNELS-1:0] irq
);

  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

  logic             ch_ok;
  reg_sel_e         sel;
  logic [WIDTH-1:0] count_arr   [CHANNELS];
  logic [WIDTH-1:0] compare_arr [CHANNELS];
  logic [WIDTH-1:0] ctrl_arr    [CHANNELS];
  logic [WIDTH-1:0] rd_mux;

  assign ch_ok = ({1'b0, ch_sel} < CH_LIMIT);
  assign sel   = reg_sel_e'(reg_sel);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic hit;
    assign hit = wr_en & ch_ok & (ch_sel == SEL_W'(g));

    hpm_counter_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk         (clk),
      .reset       (reset),
      .event_pulse (event_i[g]),
      .count_we    (hit & (sel == REG_COUNT)),
      .compare_we  (hit & (sel == REG_COMPARE)),
      .ctrl_we     (hit & (sel == REG_CTRL)),
      .wdata       (wdata),
      .count       (count_arr[g]),
      .compare     (compare_arr[g]),
      .ctrl        (ctrl_arr[g]),
      .irq         (irq[g])
    );
  end

  // Select the addressed register; invalid channel or reserved slot reads 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_ok && (ch_sel == SEL_W'(i))) begin
        case (sel)
          REG_COUNT:   rd_mux = count_arr[i];
          REG_COMPARE: rd_mux = compare_arr[i];
          REG_CTRL:    rd_mux = ctrl_arr[i];
          default:     rd_mux = '0;
        endcase
      end
    end
  end

  // Registered read response with single-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

endmodule
